// File: rtl/res_arb_pkg.sv
// Shared constants and types for the result-RAM arbiter.
// Provides RAM geometry, requester identifiers and the read-tag entry.
package res_arb_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_A    = 2'd1,
        PORT_B    = 2'd2
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;

endpackage

// File: rtl/res_arb_pick.sv
// Two-way grant picker with round-robin or fixed priority and owner lock.
// Ports: clk, reset (async active-low), a/b_req, a/b_lock in; a/b_gnt out.
module res_arb_pick
    import res_arb_pkg::*;
#(
    parameter bit PRIO_A = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    input  logic a_lock,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    port_e r_own;
    port_e r_last;
    logic  w_a_gnt;
    logic  w_b_gnt;

    // A locked owner excludes the other port even while it is idle.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        unique case (r_own)
            PORT_A: w_a_gnt = a_req;
            PORT_B: w_b_gnt = b_req;
            default: begin
                if (a_req && b_req) begin
                    if (PRIO_A || (r_last == PORT_B)) begin
                        w_a_gnt = 1'b1;
                    end else begin
                        w_b_gnt = 1'b1;
                    end
                end else begin
                    w_a_gnt = a_req;
                    w_b_gnt = b_req;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_own  <= PORT_NONE;
            r_last <= PORT_B;
        end else if (a_req && w_a_gnt) begin
            r_last <= PORT_A;
            r_own  <= a_lock ? PORT_A : PORT_NONE;
        end else if (b_req && w_b_gnt) begin
            r_last <= PORT_B;
            r_own  <= b_lock ? PORT_B : PORT_NONE;
        end
    end

    assign a_gnt = w_a_gnt;
    assign b_gnt = w_b_gnt;

endmodule

// File: rtl/res_mem_arbiter.sv
// Shares the single-port result RAM between engine (A) and host (B).
// Ports: per-port req/wr/lock/addr/wdata in, gnt/rvalid/rdata out;
// registered RAM pins res_rd/res_wr/res_addr/res_do, res_di in; busy out.
module res_mem_arbiter #(
    parameter int ADDR_W = res_arb_pkg::ADDR_W,
    parameter int DATA_W = res_arb_pkg::DATA_W,
    parameter int RD_LAT = 1,
    parameter bit PRIO_A = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              res_rd,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_do,
    input  logic [DATA_W-1:0] res_di,
    output logic              busy
);

    import res_arb_pkg::*;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_xfer_a;
    logic              w_xfer_b;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_busy;
    tag_t              w_tag_in;

    logic              r_res_rd;
    logic              r_res_wr;
    logic [ADDR_W-1:0] r_res_addr;
    logic [DATA_W-1:0] r_res_do;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    tag_t              r_tag [RD_LAT+1];

    res_arb_pick #(
        .PRIO_A (PRIO_A)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .a_req  (a_req),
        .b_req  (b_req),
        .a_lock (a_lock),
        .b_lock (b_lock),
        .a_gnt  (w_a_gnt),
        .b_gnt  (w_b_gnt)
    );

    assign w_xfer_a = a_req & w_a_gnt;
    assign w_xfer_b = b_req & w_b_gnt;
    assign w_wr     = w_xfer_a ? a_wr    : b_wr;
    assign w_addr   = w_xfer_a ? a_addr  : b_addr;
    assign w_wdata  = w_xfer_a ? a_wdata : b_wdata;

    always_comb begin
        w_tag_in.valid = (w_xfer_a | w_xfer_b) & ~w_wr;
        w_tag_in.port  = w_xfer_a ? PORT_A : PORT_B;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_rd   <= 1'b0;
            r_res_wr   <= 1'b0;
            r_res_addr <= '0;
            r_res_do   <= '0;
        end else if (w_xfer_a || w_xfer_b) begin
            r_res_rd   <= ~w_wr;
            r_res_wr   <= w_wr;
            r_res_addr <= w_addr;
            if (w_wr) begin
                r_res_do <= w_wdata;
            end
        end else begin
            r_res_rd <= 1'b0;
            r_res_wr <= 1'b0;
        end
    end

    // Stage i holds the tag of the read issued i edges ago; the RAM data
    // for the tag at stage RD_LAT is on res_di during this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '{valid: 1'b0, port: PORT_NONE};
            end
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_a_rvalid <= r_tag[RD_LAT].valid
                        && (r_tag[RD_LAT].port == PORT_A);
            r_b_rvalid <= r_tag[RD_LAT].valid
                        && (r_tag[RD_LAT].port == PORT_B);
            if (r_tag[RD_LAT].valid && (r_tag[RD_LAT].port == PORT_A)) begin
                r_a_rdata <= res_di;
            end
            if (r_tag[RD_LAT].valid && (r_tag[RD_LAT].port == PORT_B)) begin
                r_b_rdata <= res_di;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            w_busy = w_busy | r_tag[i].valid;
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign res_rd   = r_res_rd;
    assign res_wr   = r_res_wr;
    assign res_addr = r_res_addr;
    assign res_do   = r_res_do;
    assign busy     = w_busy;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Directed bench for res_mem_arbiter: instance 0 round-robin RD_LAT=1,
// instance 1 A-priority RD_LAT=3, each with its own RAM model.
module tb_res_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_req [2], b_req [2], a_wr [2], b_wr [2];
    logic       a_lock [2], b_lock [2];
    logic [13:0] a_addr [2], b_addr [2];
    logic [7:0]  a_wdata [2], b_wdata [2];
    logic       a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
    logic [7:0]  a_rdata [2], b_rdata [2];
    logic       res_rd [2], res_wr [2];
    logic [13:0] res_addr [2];
    logic [7:0]  res_do [2], res_di [2];
    logic       busy [2];

    int checks = 0;
    int failures = 0;

    res_mem_arbiter #(
        .ADDR_W(14), .DATA_W(8), .RD_LAT(1), .PRIO_A(1'b0)
    ) u_rr (
        .clk(clk), .reset(rst_n),
        .a_req(a_req[0]), .a_wr(a_wr[0]), .a_lock(a_lock[0]),
        .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_wr(b_wr[0]), .b_lock(b_lock[0]),
        .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
        .res_rd(res_rd[0]), .res_wr(res_wr[0]), .res_addr(res_addr[0]),
        .res_do(res_do[0]), .res_di(res_di[0]), .busy(busy[0])
    );

    res_mem_arbiter #(
        .ADDR_W(14), .DATA_W(8), .RD_LAT(3), .PRIO_A(1'b1)
    ) u_pa (
        .clk(clk), .reset(rst_n),
        .a_req(a_req[1]), .a_wr(a_wr[1]), .a_lock(a_lock[1]),
        .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_wr(b_wr[1]), .b_lock(b_lock[1]),
        .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
        .res_rd(res_rd[1]), .res_wr(res_wr[1]), .res_addr(res_addr[1]),
        .res_do(res_do[1]), .res_di(res_di[1]), .busy(busy[1])
    );

    // RAM models: read data appears RD_LAT edges after the strobe edge.
    logic [7:0] mem [2][16384];
    logic [7:0] rp [2][3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (res_wr[i]) mem[i][res_addr[i]] <= res_do[i];
            rp[i][0] <= res_rd[i] ? mem[i][res_addr[i]] : 8'hEE;
            rp[i][1] <= rp[i][0];
            rp[i][2] <= rp[i][1];
        end
    end

    assign res_di[0] = rp[0][0];
    assign res_di[1] = rp[1][2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int d);
        a_req[d] = 0; b_req[d] = 0; a_wr[d] = 0; b_wr[d] = 0;
        a_lock[d] = 0; b_lock[d] = 0;
        a_addr[d] = '0; b_addr[d] = '0; a_wdata[d] = '0; b_wdata[d] = '0;
    endtask

    task automatic cmd_a(input int d, input logic wr, input logic lk,
                         input logic [13:0] ad, input logic [7:0] wd);
        a_req[d] = 1; a_wr[d] = wr; a_lock[d] = lk;
        a_addr[d] = ad; a_wdata[d] = wd;
    endtask

    task automatic cmd_b(input int d, input logic wr, input logic lk,
                         input logic [13:0] ad, input logic [7:0] wd);
        b_req[d] = 1; b_wr[d] = wr; b_lock[d] = lk;
        b_addr[d] = ad; b_wdata[d] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    logic [7:0] tbl [4];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 16384; j++) mem[d][j] = 8'h00;
            mem[d][14'h0081] = 8'h05;
            mem[d][14'h0000] = 8'h11;
            mem[d][14'h0001] = 8'h22;
            mem[d][14'h0002] = 8'h33;
            mem[d][14'h0003] = 8'h44;
            mem[d][14'h0010] = 8'h1A;
            mem[d][14'h0020] = 8'h2B;
            mem[d][14'h0030] = 8'h3C;
        end
        tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
        rst_n = 0;
        idle(0);
        idle(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_gnt", a_gnt[0], 0);
        chk("rst_b_gnt", b_gnt[0], 0);
        chk("rst_res_rd", res_rd[0], 0);
        chk("rst_res_wr", res_wr[0], 0);
        chk("rst_res_addr", res_addr[0], 0);
        chk("rst_res_do", res_do[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_a_rvalid", a_rvalid[0], 0);
        chk("rst_a_rdata", a_rdata[0], 0);
        chk("rst_b_rvalid", b_rvalid[0], 0);
        rst_n = 1;

        // single A read of 0x0081
        tick();
        cmd_a(0, 0, 0, 14'h0081, 8'h00);
        #1;
        chk("t1_a_gnt", a_gnt[0], 1);
        chk("t1_b_gnt", b_gnt[0], 0);
        tick();
        idle(0);
        chk("t1_res_rd", res_rd[0], 1);
        chk("t1_res_addr", res_addr[0], 14'h0081);
        chk("t1_busy", busy[0], 1);
        tick();
        chk("t1_res_rd_off", res_rd[0], 0);
        chk("t1_rv_early", a_rvalid[0], 0);
        tick();
        chk("t1_rvalid", a_rvalid[0], 1);
        chk("t1_rdata", a_rdata[0], 8'h05);
        chk("t1_busy_end", busy[0], 0);
        tick();
        chk("t1_rvalid_pulse", a_rvalid[0], 0);

        // round-robin alternation
        do_reset();
        cmd_a(0, 0, 0, 14'h0010, 8'h00);
        cmd_b(0, 0, 0, 14'h0020, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_gnt", a_gnt[0], (i % 2 == 0) ? 1 : 0);
            chk("rr_b_gnt", b_gnt[0], (i % 2 == 1) ? 1 : 0);
            tick();
        end
        idle(0);
        repeat (3) tick();

        // A locked burst, B waiting throughout
        do_reset();
        cmd_b(0, 0, 0, 14'h0020, 8'h00);
        for (int n = 0; n < 6; n++) begin
            if (n < 4) cmd_a(0, 0, 1, 14'(n), 8'h00);
            else if (n == 4) cmd_a(0, 1, 0, 14'h0082, 8'h07);
            else a_req[0] = 0;
            #1;
            chk("lk_a_gnt", a_gnt[0], (n < 5) ? 1 : 0);
            chk("lk_b_gnt", b_gnt[0], (n == 5) ? 1 : 0);
            tick();
            if (n < 4) begin
                chk("lk_rd", res_rd[0], 1);
                chk("lk_addr", res_addr[0], n);
            end else if (n == 4) begin
                chk("lk_wr", res_wr[0], 1);
                chk("lk_waddr", res_addr[0], 14'h0082);
                chk("lk_wdo", res_do[0], 8'h07);
            end else begin
                chk("lk_b_rd", res_rd[0], 1);
                chk("lk_b_addr", res_addr[0], 14'h0020);
            end
            if (n >= 2) begin
                chk("lk_a_rvalid", a_rvalid[0], 1);
                chk("lk_a_rdata", a_rdata[0], tbl[n-2]);
            end
        end
        idle(0);
        tick();
        tick();
        chk("lk_b_rvalid", b_rvalid[0], 1);
        chk("lk_b_rdata", b_rdata[0], 8'h2B);

        // B write then read-back at top address
        tick();
        cmd_b(0, 1, 0, 14'h3FFF, 8'hAA);
        #1;
        chk("wr_b_gnt", b_gnt[0], 1);
        tick();
        chk("wr_res_wr", res_wr[0], 1);
        chk("wr_res_addr", res_addr[0], 14'h3FFF);
        chk("wr_res_do", res_do[0], 8'hAA);
        cmd_b(0, 0, 0, 14'h3FFF, 8'h00);
        #1;
        chk("rb_b_gnt", b_gnt[0], 1);
        tick();
        idle(0);
        chk("rb_res_rd", res_rd[0], 1);
        tick();
        tick();
        chk("rb_b_rvalid", b_rvalid[0], 1);
        chk("rb_b_rdata", b_rdata[0], 8'hAA);

        // reset with a locked read in flight
        tick();
        cmd_a(0, 0, 1, 14'h0081, 8'h00);
        #1;
        tick();
        idle(0);
        chk("mr_busy_pre", busy[0], 1);
        #1;
        rst_n = 0;
        #1;
        chk("mr_busy", busy[0], 0);
        chk("mr_res_rd", res_rd[0], 0);
        chk("mr_res_addr", res_addr[0], 0);
        chk("mr_res_do", res_do[0], 0);
        rst_n = 1;
        tick();
        chk("mr_no_rv1", a_rvalid[0], 0);
        tick();
        chk("mr_no_rv2", a_rvalid[0], 0);
        cmd_b(0, 0, 0, 14'h0020, 8'h00);
        #1;
        chk("mr_unlocked_b", b_gnt[0], 1);
        cmd_a(0, 0, 0, 14'h0010, 8'h00);
        #1;
        chk("mr_tie_a", a_gnt[0], 1);
        chk("mr_tie_b", b_gnt[0], 0);
        idle(0);
        tick();

        // A strict priority, RD_LAT=3 instance
        cmd_a(1, 0, 0, 14'h0010, 8'h00);
        cmd_b(1, 0, 0, 14'h0020, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pa_a_gnt", a_gnt[1], 1);
            chk("pa_b_gnt", b_gnt[1], 0);
            tick();
        end
        a_req[1] = 0;
        #1;
        chk("pa_b_after", b_gnt[1], 1);
        tick();
        idle(1);
        repeat (6) tick();

        // interleaved reads A,B,A with RD_LAT=3
        cmd_a(1, 0, 0, 14'h0010, 8'h00);
        tick();
        idle(1);
        cmd_b(1, 0, 0, 14'h0020, 8'h00);
        #1;
        chk("il_b_gnt", b_gnt[1], 1);
        tick();
        idle(1);
        cmd_a(1, 0, 0, 14'h0030, 8'h00);
        tick();
        idle(1);
        tick();
        chk("il_k3_arv", a_rvalid[1], 0);
        chk("il_k3_brv", b_rvalid[1], 0);
        chk("il_k3_busy", busy[1], 1);
        tick();
        chk("il_k4_arv", a_rvalid[1], 1);
        chk("il_k4_ard", a_rdata[1], 8'h1A);
        chk("il_k4_brv", b_rvalid[1], 0);
        tick();
        chk("il_k5_brv", b_rvalid[1], 1);
        chk("il_k5_brd", b_rdata[1], 8'h2B);
        chk("il_k5_arv", a_rvalid[1], 0);
        tick();
        chk("il_k6_arv", a_rvalid[1], 1);
        chk("il_k6_ard", a_rdata[1], 8'h3C);
        chk("il_k6_busy", busy[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_mem_arbiter.md
# res_mem_arbiter

Two-port arbiter that shares the single-port 16384×8 result RAM between the distance-transform engine (port A) and a host/readback requester (port B). It serializes accesses at one per cycle, drives the RAM's `res_rd`/`res_wr`/`res_addr`/`res_do` pins, and routes the returned `res_di` back to the requester that issued each read. A lock input lets the engine hold the RAM across a neighbourhood read-modify-write sequence.

## Interface
- `ADDR_W`, 14, RAM address width (16384 pixels)
- `DATA_W`, 8, RAM data width
- `RD_LAT`, 1, cycles from `res_rd` high to `res_di` valid (1..4)
- `PRIO_A`, 0, 1 = port A strict priority; 0 = round-robin
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `a_req`, `b_req`  in  1  access request; hold with command until granted
- `a_wr`, `b_wr`  in  1  1 = write, 0 = read
- `a_lock`, `b_lock`  in  1  keep ownership after this grant
- `a_addr`, `b_addr`  in  ADDR_W  access address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_gnt`, `b_gnt`  out  1  combinational; transfer occurs at an edge where req&gnt
- `a_rvalid`, `b_rvalid`  out  1  one-cycle read-return strobe
- `a_rdata`, `b_rdata`  out  DATA_W  read data, valid with rvalid
- `res_rd`, `res_wr`  out  1  RAM strobes, registered
- `res_addr`  out  ADDR_W  RAM address, registered
- `res_do`  out  DATA_W  RAM write data, registered
- `res_di`  in  DATA_W  RAM read data
- `busy`  out  1  high while any read is in flight

## Operation
- Arbitration (combinational gnt): at most one of `a_gnt`/`b_gnt` high per cycle; gnt never high without its req.
- Owner register `own` (A/B/none). If `own`=X and `X_lock` was high at X's last grant, only X may be granted until X completes a granted transfer with lock low; the other port waits even if X is idle.
- Unlocked, `PRIO_A`=1: A wins when both request. `PRIO_A`=0: winner is the port not granted most recently (`last` pointer, reset to B so A wins first tie).
- On transfer edge: register `res_rd`=!wr, `res_wr`=wr, `res_addr`, `res_do`=wdata (write only); update `last`, `own`.
- No transfer: `res_rd`=`res_wr`=0; `res_addr`/`res_do` hold.
- Read tag pipeline, depth RD_LAT+1, entries {valid, port}; capture `res_di` at stage RD_LAT into `X_rdata`, pulse `X_rvalid`.
- Order preserved: returns in issue order; write-after-read and read-after-write to the same address follow issue order (RAM semantics).
- `busy` = OR of tag-valid bits.

## Timing
- Reset values: all gnt (combinational, low because no owner lock) 0; `res_rd`, `res_wr`, `res_addr`, `res_do`, rvalid, rdata, `busy` all 0; `own`=none; `last`=B; tag pipeline cleared.
- Transfer at edge k → RAM strobe high during cycle k..k+1 (exactly one cycle).
- Read: `res_di` valid cycle k+RD_LAT; `X_rvalid`/`X_rdata` high cycle k+RD_LAT+1 (latency RD_LAT+1 edges).
- Throughput: one transfer per cycle, back-to-back from either port, no bubbles.
- Requester changing command while req high and ungranted: undefined; command sampled only at transfer edge.
- Reset asserted mid-operation: in-flight reads discarded, no rvalid issued afterwards, lock released.
- Simultaneous lock release by owner and request by other port: release takes effect on that edge; other port eligible next cycle.

## Structure
- Package `res_arb_pkg`: `ADDR_W`, `DATA_W` constants, `port_e` enum {PORT_NONE, PORT_A, PORT_B}, tag struct {valid, port}.
- Sub-module `res_arb_pick`: two-way round-robin/priority picker with lock/owner state; top holds RAM registers and tag pipeline.

## Test plan
- A reads addr 0x0081 (RAM holds 0x05), B idle → `a_gnt` same cycle, `res_rd`=1/`res_addr`=0x0081 next cycle, `a_rvalid` with `a_rdata`=0x05 two edges after transfer (RD_LAT=1).
- Both request continuously, `PRIO_A`=0 → grants alternate A,B,A,B; with `PRIO_A`=1 → A every cycle, B starved until A drops req.
- A locks 4 reads (0x0000–0x0003) then unlocked write 0x07 to 0x0082 while B requests throughout → B granted only on cycle after A's write; RAM sees 5 A ops contiguous.
- Interleaved A read 0x10, B read 0x20, A read 0x30 back-to-back, RD_LAT=3 → rvalids A,B,A in order at edges k+4,k+5,k+6 with correct data.
- B writes 0xAA to 0x3FFF then reads 0x3FFF next cycle → `b_rdata`=0xAA.
- Reset pulsed one cycle after an A read transfer → no `a_rvalid`, all outputs 0, `busy`=0, A granted first on next tie.
